diffeq_loop_ctrl: RTL
=====================

# diffeq_loop_ctrl

Iteration controller that sits directly upstream of the single-step differential-equation HLSM engine. It takes initial conditions from the host and launches the engine. After each step it feeds the engine's u1/x1/y1 back as the next u/x/y, and repeats while the engine's continue flag c is 1. It stops at an iteration limit or a step timeout, then returns the final state to the host with a one-cycle Done pulse.

## Interface
- WIDTH, 32: signed datapath width of all u/x/y/dx/a/three values.
- MAX_ITER, 1024: maximum engine steps per run; legal range 1..65535.
- TIMEOUT, 64: cycles allowed per step between step_start and step_done; legal range ≥ 16.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  host run request; sampled only in IDLE.
- u0, x0, y0, dx, a, three  in  WIDTH signed  initial state and constants, latched on an accepted Start.
- Done  out  1  one-cycle pulse marking the end of a run.
- u_out, x_out, y_out  out  WIDTH signed  final state; valid from Done and held until the next accepted Start.
- iter_count  out  16  number of completed engine steps in the last run.
- limit_hit  out  1  run ended because iter_count reached MAX_ITER while c was still 1.
- timeout  out  1  run ended because a step did not complete within TIMEOUT cycles.
- step_start  out  1  engine Start; a one-cycle pulse.
- step_u, step_x, step_y, step_dx, step_a, step_three  out  WIDTH signed  engine operands.
- step_done  in  1  engine Done.
- step_u1, step_x1, step_y1  in  WIDTH signed  engine results.
- step_c  in  1  engine continue flag, (x+dx) < a.

## Operation
- States: IDLE, KICK, WAIT_STEP, FINISH.
- IDLE
  - Start=1: latch u0/x0/y0 into step_u/step_x/step_y, latch dx/a/three, clear iter_count/limit_hit/timeout, go to KICK.
  - Start=0: stay.
- KICK: step_start=1 for this state only; clear the timeout counter; go to WAIT_STEP.
- WAIT_STEP, step_done=1:
  - Copy step_u1/x1/y1 into step_u/x/y and into u_out/x_out/y_out.
  - iter_count+1.
  - If step_c=1 and new iter_count < MAX_ITER, go to KICK.
  - Else set limit_hit = step_c, go to FINISH.
- WAIT_STEP, step_done=0:
  - Increment the timeout counter.
  - When the counter reaches TIMEOUT-1: set timeout=1, copy the current step_u/x/y to u_out/x_out/y_out, go to FINISH.
  - If step_done and the timeout terminal count occur in the same cycle, step_done wins.
- FINISH: Done=1 for one cycle; go to IDLE.
- The loop is do-while: every run performs at least one engine step.
- Operand stability: step_* operands are held constant from KICK until step_done, because the engine reads its inputs across several states.
- Ignored inputs:
  - step_done outside WAIT_STEP.
  - Start outside IDLE, including during the FINISH cycle.
- Arithmetic: values pass through unmodified. There is no saturation or width change, and wrap behaviour belongs to the engine. iter_count is unsigned and never exceeds MAX_ITER.

## Timing
- Reset (Rst=0, asynchronous):
  - State goes to IDLE.
  - These outputs reset to 0: Done, step_start, all step_* operands, u_out/x_out/y_out, iter_count, limit_hit, timeout.
- Reset mid-run: the run is abandoned with no Done pulse. An in-flight engine step_done is later ignored because the controller is in IDLE.
- All outputs are registered.
- Cycle sequence for a Start accepted at edge k:
  - step_start is high during cycle k+1.
  - The engine samples it at edge k+2.
- Per-step controller overhead: 2 cycles (KICK plus the step_done capture edge), on top of engine latency (about 10 cycles).
- Done rises one cycle after the terminating step_done edge.
- A new Start is accepted starting with the cycle after Done.

## Test plan
- Three iterations: x0=0, dx=1, a=3, u0=y0=0, three=3, with the real engine.
  - Expect exactly 3 step_start pulses and one Done.
  - Expect x_out=3, u_out=0, y_out=0, iter_count=3, limit_hit=0, timeout=0.
- Single step: x0=5, dx=1, a=3.
  - Expect one step_start, iter_count=1, x_out=6, Done once.
- Iteration limit: MAX_ITER=4, x0=0, dx=1, a=100.
  - Expect iter_count=4, x_out=4, limit_hit=1.
- Timeout: stub engine never asserts step_done, TIMEOUT=16, x0=7.
  - Expect Done 17 cycles after step_start.
  - Expect timeout=1, x_out=7, iter_count=0.
- Reset mid-run: assert Rst=0 during the second WAIT_STEP.
  - Expect all outputs 0 immediately and no Done pulse.
  - A late step_done is ignored.
  - A following run with x0=0, dx=1, a=3 gives the correct result x_out=3.
- Start while busy, plus operand stability:
  - Pulse Start during WAIT_STEP and during FINISH; both are ignored.
  - Check that step_* operands are constant for every cycle between step_start and step_done.

Source files
------------

// File: rtl/diffeq_loop_ctrl.sv
// diffeq_loop_ctrl
// Iteration controller for a single-step differential-equation engine.
// It latches the initial state and constants from the host, then launches
// the engine repeatedly. After each step it feeds u1/x1/y1 back as the
// next u/x/y and continues while the engine's continue flag is set. A run
// also ends when it reaches the iteration limit or when a step times out.
// At the end of a run the final state is returned with a one-cycle done pulse.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i                 host run request, sampled only in IDLE
//   u0_i..three_i           initial state and constants, latched on start
//   done_o                  one-cycle end-of-run pulse
//   u_out_o/x_out_o/y_out_o final state, held until the next accepted start
//   iter_count_o            completed engine steps in the last run
//   limit_hit_o, timeout_o  run-termination reasons
//   step_start_o            engine start pulse
//   step_*_o                engine operands, stable from KICK until step_done
//   step_done_i             engine done
//   step_u1_i..step_y1_i    engine results
//   step_c_i                engine continue flag
module diffeq_loop_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 1024,
  parameter int TIMEOUT  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic signed [WIDTH-1:0] u0_i,
  input  logic signed [WIDTH-1:0] x0_i,
  input  logic signed [WIDTH-1:0] y0_i,
  input  logic signed [WIDTH-1:0] dx_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] three_i,
  output logic                    done_o,
  output logic signed [WIDTH-1:0] u_out_o,
  output logic signed [WIDTH-1:0] x_out_o,
  output logic signed [WIDTH-1:0] y_out_o,
  output logic [15:0]             iter_count_o,
  output logic                    limit_hit_o,
  output logic                    timeout_o,
  output logic                    step_start_o,
  output logic signed [WIDTH-1:0] step_u_o,
  output logic signed [WIDTH-1:0] step_x_o,
  output logic signed [WIDTH-1:0] step_y_o,
  output logic signed [WIDTH-1:0] step_dx_o,
  output logic signed [WIDTH-1:0] step_a_o,
  output logic signed [WIDTH-1:0] step_three_o,
  input  logic                    step_done_i,
  input  logic signed [WIDTH-1:0] step_u1_i,
  input  logic signed [WIDTH-1:0] step_x1_i,
  input  logic signed [WIDTH-1:0] step_y1_i,
  input  logic                    step_c_i
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [15:0]   ITER_MAX = 16'(MAX_ITER);

  typedef enum logic [1:0] {IDLE, KICK, WAIT_STEP, FINISH} state_t;

  state_t                  state_q;
  logic                    done_q;
  logic                    step_start_q;
  logic                    limit_hit_q;
  logic                    timeout_q;
  logic [15:0]             iter_q;
  logic [15:0]             iter_d;
  logic [CW-1:0]           tmo_cnt_q;
  logic signed [WIDTH-1:0] u_q, x_q, y_q;
  logic signed [WIDTH-1:0] dx_q, a_q, three_q;
  logic signed [WIDTH-1:0] u_out_q, x_out_q, y_out_q;

  // The step count after the step that is completing now. This value
  // decides whether the loop continues.
  assign iter_d = iter_q + 16'd1;

  // The FSM and all of its registered outputs. step_start and done are
  // set on the edge that enters KICK or FINISH. As a result they are high
  // for exactly the cycle spent in that state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      step_start_q <= 1'b0;
      limit_hit_q  <= 1'b0;
      timeout_q    <= 1'b0;
      iter_q       <= '0;
      tmo_cnt_q    <= '0;
      u_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      dx_q         <= '0;
      a_q          <= '0;
      three_q      <= '0;
      u_out_q      <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
    end else begin
      done_q       <= 1'b0;
      step_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            u_q          <= u0_i;
            x_q          <= x0_i;
            y_q          <= y0_i;
            dx_q         <= dx_i;
            a_q          <= a_i;
            three_q      <= three_i;
            iter_q       <= '0;
            limit_hit_q  <= 1'b0;
            timeout_q    <= 1'b0;
            step_start_q <= 1'b1;
            state_q      <= KICK;
          end
        end
        KICK: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT_STEP;
        end
        WAIT_STEP: begin
          // A step_done that arrives on the terminal-count cycle still
          // counts as a completed step. It takes priority over the timeout.
          if (step_done_i) begin
            u_q     <= step_u1_i;
            x_q     <= step_x1_i;
            y_q     <= step_y1_i;
            u_out_q <= step_u1_i;
            x_out_q <= step_x1_i;
            y_out_q <= step_y1_i;
            iter_q  <= iter_d;
            if (step_c_i && (iter_d < ITER_MAX)) begin
              step_start_q <= 1'b1;
              state_q      <= KICK;
            end else begin
              limit_hit_q <= step_c_i;
              done_q      <= 1'b1;
              state_q     <= FINISH;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            u_out_q   <= u_q;
            x_out_q   <= x_q;
            y_out_q   <= y_q;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done_o       = done_q;
  assign step_start_o = step_start_q;
  assign limit_hit_o  = limit_hit_q;
  assign timeout_o    = timeout_q;
  assign iter_count_o = iter_q;
  assign u_out_o      = u_out_q;
  assign x_out_o      = x_out_q;
  assign y_out_o      = y_out_q;
  assign step_u_o     = u_q;
  assign step_x_o     = x_q;
  assign step_y_o     = y_q;
  assign step_dx_o    = dx_q;
  assign step_a_o     = a_q;
  assign step_three_o = three_q;

endmodule
